// File: rtl/clk_period_monitor.sv
// clk_period_monitor: synchronises a slow asynchronous clock-like input,
// emits edge pulses, measures the rise-to-rise period in clk_in cycles and
// reports lock once LOCK_COUNT consecutive periods fall within tolerance.
module clk_period_monitor #(
  parameter int unsigned EXPECTED_PERIOD = 1000,
  parameter int unsigned TOLERANCE       = 2,
  parameter int unsigned LOCK_COUNT      = 4,
  parameter int unsigned TIMEOUT         = 2 * EXPECTED_PERIOD,
  localparam int unsigned CNT_W          = $clog2(TIMEOUT + 1)
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             sig_in,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int unsigned       MC_W      = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W:0]    EXP_C     = (CNT_W + 1)'(EXPECTED_PERIOD);
  localparam logic [CNT_W:0]    TOL_C     = (CNT_W + 1)'(TOLERANCE);
  localparam logic [MC_W-1:0]   LOCK_C    = MC_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  logic             s1_q, s2_q, s3_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [MC_W-1:0]  match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             period_valid_q, period_valid_d;
  logic             timeout_q, timeout_d;

  logic             rise_c, fall_c;
  logic             cnt_at_max_c;
  logic [CNT_W:0]   cnt_ext_c, diff_c;
  logic             match_c;
  logic [MC_W-1:0]  match_cnt_inc_c;

  // Three-flop synchroniser; the third stage gives the previous value for edge detection
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Monitor state, cycle counter and registered measurement outputs
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      match_cnt_q    <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      match_cnt_q    <= match_cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      timeout_q      <= timeout_d;
    end
  end

  // Edge detect and tolerance match; difference taken one bit wider so it never wraps
  always_comb begin
    rise_c          = s2_q & ~s3_q;
    fall_c          = ~s2_q & s3_q;
    cnt_at_max_c    = (cnt_q == TIMEOUT_C);
    cnt_ext_c       = {1'b0, cnt_q};
    diff_c          = (cnt_ext_c >= EXP_C) ? (cnt_ext_c - EXP_C) : (EXP_C - cnt_ext_c);
    match_c         = (diff_c <= TOL_C);
    match_cnt_inc_c = match_cnt_q + MC_W'(1);
  end

  // Next-state logic: a rise takes priority over a saturated counter
  always_comb begin
    state_d        = state_q;
    match_cnt_d    = match_cnt_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    timeout_d      = timeout_q;
    cnt_d          = cnt_at_max_c ? cnt_q : (cnt_q + CNT_W'(1));

    if (rise_c) begin
      cnt_d     = CNT_W'(1);
      timeout_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          // No reference edge yet, so this rise only arms the measurement
          state_d     = ACQUIRE;
          match_cnt_d = '0;
        end
        ACQUIRE: begin
          period_d       = cnt_q;
          period_valid_d = 1'b1;
          if (match_c) begin
            match_cnt_d = match_cnt_inc_c;
            if (match_cnt_inc_c >= LOCK_C) begin
              state_d = LOCKED;
            end
          end else begin
            match_cnt_d = '0;
          end
        end
        LOCKED: begin
          period_d       = cnt_q;
          period_valid_d = 1'b1;
          if (!match_c) begin
            state_d     = ACQUIRE;
            match_cnt_d = '0;
          end
        end
        default: begin
          state_d     = IDLE;
          match_cnt_d = '0;
        end
      endcase
    end else if (cnt_at_max_c) begin
      timeout_d   = 1'b1;
      state_d     = IDLE;
      match_cnt_d = '0;
    end
  end

  assign rise_pulse   = rise_c;
  assign fall_pulse   = fall_c;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign locked       = (state_q == LOCKED);
  assign timeout      = timeout_q;

endmodule
